// File: rtl/softplus_backward.sv
// ---------------------------------------------------------------------------
// softplus_backward
//
// Backward pass of the Softplus activation for one float32 element at a time:
//     grad_out = grad_in / (1 + exp(-x))   (= grad_in * sigmoid(x))
// One exp, one add and one divide unit are shared over a four-step sequence
// (EXP -> ADD -> DIV -> DONE); each unit's result lands in a register, so
// every state owns exactly one unit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   x / grad_in are valid
//   in_ready   block can accept a pair (IDLE only)
//   x          forward-pass input, float32
//   grad_in    upstream gradient, float32
//   out_valid  grad_out is valid (DONE only)
//   out_ready  consumer accepts grad_out
//   grad_out   result, float32 (registered)
//   busy       high whenever the block is not IDLE
//
// Float units: round-to-nearest-even, subnormal inputs/outputs flushed to
// zero, any NaN result is the canonical quiet NaN 0x7FC00000.
// ---------------------------------------------------------------------------
module softplus_backward (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] grad_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] grad_out,
    output logic        busy
);

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Fixed-point constants in Q30 (value * 2^30).
    localparam longint LOG2E_Q30 = 64'sd1549082005;
    localparam longint LN2_Q30   = 64'sd744261118;
    localparam longint ONE_Q30   = 64'sd1073741824;
    localparam longint C2_Q30    = 64'sd536870912;   // 1/2
    localparam longint C3_Q30    = 64'sd178956971;   // 1/6
    localparam longint C4_Q30    = 64'sd44739243;    // 1/24
    localparam longint C5_Q30    = 64'sd8947849;     // 1/120
    localparam longint C6_Q30    = 64'sd1491308;     // 1/720
    localparam longint HALF_Q24  = 64'sd8388608;

    // -----------------------------------------------------------------------
    // Shared rounding/packing for the adder and divider.
    // s_mant carries the significand with the hidden bit at [26], fraction at
    // [25:3] and guard/round/sticky at [2:0].
    // -----------------------------------------------------------------------
    function automatic logic [31:0] round_pack(input logic   sign,
                                               input longint exp_in,
                                               input longint s_mant);
        longint e_v;
        longint m_v;
        longint grs;
        logic   up;
        e_v = exp_in;
        grs = s_mant & 64'sd7;
        up  = (grs > 64'sd4) || ((grs == 64'sd4) && (((s_mant >> 3) & 64'sd1) != 64'sd0));
        m_v = (s_mant >> 3) + (up ? 64'sd1 : 64'sd0);
        if (m_v >= 64'sd16777216) begin
            m_v = m_v >> 1;
            e_v = e_v + 64'sd1;
        end
        if (e_v >= 64'sd255) begin
            return {sign, 8'hFF, 23'd0};
        end
        if (e_v <= 64'sd0) begin
            return {sign, 31'd0};
        end
        return {sign, 8'(e_v), 23'(m_v)};
    endfunction

    // -----------------------------------------------------------------------
    // exp(a): a*log2(e) is split into k + f with k rounded to nearest, so
    // f lies in [-0.5, 0.5); 2^f = e^(f*ln2) comes from a degree-6 Taylor
    // polynomial evaluated in Q30, and k goes straight into the exponent.
    // -----------------------------------------------------------------------
    function automatic logic [31:0] fp_exp(input logic [31:0] a);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        longint      mant;
        longint      fx;
        longint      y;
        longint      k;
        longint      f;
        longint      z;
        longint      p;
        longint      be;
        s = a[31];
        e = a[30:23];
        m = a[22:0];
        if ((e == 8'hFF) && (m != 23'd0)) begin
            return FP_QNAN;
        end
        // |a| >= 128 is far outside the float32 range of exp (and covers inf).
        if (e >= 8'd134) begin
            return s ? 32'h0000_0000 : 32'h7F80_0000;
        end
        // |a| < 2^-24 (zero and subnormals included) rounds to exactly 1.0.
        if (e < 8'd103) begin
            return FP_ONE;
        end
        mant = longint'({1'b1, m});
        // fx = |a| in Q24
        if (e >= 8'd126) begin
            fx = mant <<< (e - 8'd126);
        end else begin
            fx = mant >>> (8'd126 - e);
        end
        y = (fx * LOG2E_Q30) >>> 30;
        if (s) begin
            y = -y;
        end
        k = (y + HALF_Q24) >>> 24;
        f = y - (k <<< 24);
        z = (f * LN2_Q30) >>> 24;
        p = C6_Q30;
        p = C5_Q30  + ((p * z) >>> 30);
        p = C4_Q30  + ((p * z) >>> 30);
        p = C3_Q30  + ((p * z) >>> 30);
        p = C2_Q30  + ((p * z) >>> 30);
        p = ONE_Q30 + ((p * z) >>> 30);
        p = ONE_Q30 + ((p * z) >>> 30);
        // p is in [0.70, 1.42]: pick the normalisation by its top bit.
        if (p >= ONE_Q30) begin
            be   = k + 64'sd127;
            mant = p >>> 7;
        end else begin
            be   = k + 64'sd126;
            mant = p >>> 6;
        end
        if (be >= 64'sd255) begin
            return 32'h7F80_0000;
        end
        if (be <= 64'sd0) begin
            return 32'h0000_0000;
        end
        return {1'b0, 8'(be), 23'(mant)};
    endfunction

    // -----------------------------------------------------------------------
    // a + b
    // -----------------------------------------------------------------------
    function automatic logic [31:0] fp_add(input logic [31:0] a_in,
                                           input logic [31:0] b_in);
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [22:0] fa;
        logic [22:0] fb;
        longint      ma;
        longint      mb;
        longint      d;
        longint      s_v;
        longint      e_v;
        logic        st;
        // Order by magnitude so a is never smaller than b.
        if (b_in[30:0] > a_in[30:0]) begin
            a = b_in;
            b = a_in;
        end else begin
            a = a_in;
            b = b_in;
        end
        sa = a[31];
        sb = b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        if (((ea == 8'hFF) && (fa != 23'd0)) || ((eb == 8'hFF) && (fb != 23'd0))) begin
            return FP_QNAN;
        end
        if (ea == 8'hFF) begin
            return ((eb == 8'hFF) && (sa != sb)) ? FP_QNAN : a;
        end
        if (ea == 8'd0) begin
            return {sa & sb, 31'd0};
        end
        if (eb == 8'd0) begin
            return a;
        end
        ma = longint'({1'b1, fa}) << 3;
        mb = longint'({1'b1, fb}) << 3;
        d  = longint'(ea) - longint'(eb);
        if (d > 64'sd26) begin
            mb = 64'sd1;
        end else begin
            st = (mb & ((64'sd1 << d) - 64'sd1)) != 64'sd0;
            mb = (mb >> d) | (st ? 64'sd1 : 64'sd0);
        end
        e_v = longint'(ea);
        if (sa == sb) begin
            s_v = ma + mb;
            if (s_v >= 64'sd134217728) begin
                s_v = (s_v >> 1) | (s_v & 64'sd1);
                e_v = e_v + 64'sd1;
            end
        end else begin
            s_v = ma - mb;
            if (s_v == 64'sd0) begin
                return 32'h0000_0000;
            end
            for (int unsigned i = 0; i < 26; i++) begin
                if (s_v < 64'sd67108864) begin
                    s_v = s_v << 1;
                    e_v = e_v - 64'sd1;
                end
            end
        end
        return round_pack(sa, e_v, s_v);
    endfunction

    // -----------------------------------------------------------------------
    // a / b
    // -----------------------------------------------------------------------
    function automatic logic [31:0] fp_div(input logic [31:0] a,
                                           input logic [31:0] b);
        logic        s;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [22:0] fa;
        logic [22:0] fb;
        logic        a_inf;
        logic        b_inf;
        logic        a_zero;
        logic        b_zero;
        longint      ma;
        longint      mb;
        longint      num;
        longint      q;
        longint      e_v;
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_inf  = (ea == 8'hFF);
        b_inf  = (eb == 8'hFF);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        if ((a_inf && (fa != 23'd0)) || (b_inf && (fb != 23'd0))) begin
            return FP_QNAN;
        end
        if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            return FP_QNAN;
        end
        if (a_inf || b_zero) begin
            return {s, 8'hFF, 23'd0};
        end
        if (b_inf || a_zero) begin
            return {s, 31'd0};
        end
        ma  = longint'({1'b1, fa});
        mb  = longint'({1'b1, fb});
        e_v = longint'(ea) - longint'(eb) + 64'sd127;
        // Pre-scale so the quotient always has its leading one at bit 26.
        if (ma < mb) begin
            num = ma << 27;
            e_v = e_v - 64'sd1;
        end else begin
            num = ma << 26;
        end
        q = num / mb;
        if ((num % mb) != 64'sd0) begin
            q = q | 64'sd1;
        end
        return round_pack(s, e_v, q);
    endfunction

    // -----------------------------------------------------------------------
    // Control and registers
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXP,
        ST_ADD,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] g_q, g_d;
    logic [31:0] t_q, t_d;
    logic [31:0] grad_q, grad_d;

    logic [31:0] exp_res;
    logic [31:0] add_res;
    logic [31:0] div_res;

    always_comb begin
        exp_res = fp_exp({~x_q[31], x_q[30:0]});
        add_res = fp_add(FP_ONE, t_q);
        div_res = fp_div(g_q, t_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            g_q     <= '0;
            t_q     <= '0;
            grad_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            g_q     <= g_d;
            t_q     <= t_d;
            grad_q  <= grad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        g_d     = g_q;
        t_d     = t_q;
        grad_d  = grad_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    g_d     = grad_in;
                    state_d = ST_EXP;
                end
            end
            ST_EXP: begin
                t_d     = exp_res;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                t_d     = add_res;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                grad_d  = div_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign grad_out  = grad_q;

endmodule
